// File: rtl/dma_xfer_sequencer.sv
// Memory-to-memory DMA sequencer: splits a copy into aligned 1/2/4-byte beats
// and paces them through the byte FIFO. Optional abort support: DMA_XFER_ABORT_EN.
module dma_xfer_sequencer #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] src_addr_i,
    input  logic [ADDR_W-1:0] dst_addr_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [LEN_W-1:0]  bytes_done_o,
    output logic              rd_req_valid_o,
    input  logic              rd_req_ready_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [2:0]        rd_size_o,
    input  logic              rd_resp_valid_i,
    input  logic              rd_resp_err_i,
    output logic              rd_resp_ready_o,
    output logic              wr_req_valid_o,
    input  logic              wr_req_ready_i,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [2:0]        wr_size_o,
    input  logic              wr_resp_valid_i,
    input  logic              wr_resp_err_i,
    output logic              fifo_rstn_o,
    output logic              fifo_rvalid_o,
    input  logic              fifo_rready_i,
    output logic [2:0]        fifo_rsize_o,
    output logic [1:0]        fifo_rladdr_o,
    output logic              fifo_wvalid_o,
    input  logic              fifo_wready_i,
    output logic [2:0]        fifo_wsize_o,
    output logic [1:0]        fifo_wladdr_o
);

    typedef enum logic [2:0] {IDLE, FLUSH, RUN, DRAIN, DONE} state_e;
    typedef enum logic {R_REQ, R_RESP} rd_state_e;
    typedef enum logic {W_REQ, W_RESP} wr_state_e;

    state_e            state_q, state_d;
    rd_state_e         rd_st_q, rd_st_d;
    wr_state_e         wr_st_q, wr_st_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic [LEN_W-1:0]  rd_rem_q, rd_rem_d, wr_rem_q, wr_rem_d;
    logic [LEN_W-1:0]  bytes_done_q, bytes_done_d;
    logic              err_q, err_d;

    logic [1:0]        rd_sz, wr_sz;
    logic [LEN_W-1:0]  rd_step, wr_step;
    logic              rd_req_valid, rd_resp_fire, rd_ok;
    logic              wr_req_valid, wr_fire, wr_resp_fire, wr_ok;
    logic              resp_err, abort_hit;

    // Largest naturally aligned beat that fits in the remaining count
    function automatic logic [1:0] beat_size(input logic [1:0] a, input logic [LEN_W-1:0] n);
        if (a == 2'b00 && n >= LEN_W'(4)) begin
            return 2'd2;
        end else if (!a[0] && n >= LEN_W'(2)) begin
            return 2'd1;
        end
        return 2'd0;
    endfunction

`ifdef DMA_XFER_ABORT_EN
    assign abort_hit = abort_i && (state_q == FLUSH || state_q == RUN);
`else
    logic unused_abort;
    assign unused_abort = abort_i;
    assign abort_hit    = 1'b0;
`endif

    assign rd_sz   = beat_size(rd_addr_q[1:0], rd_rem_q);
    assign wr_sz   = beat_size(wr_addr_q[1:0], wr_rem_q);
    assign rd_step = LEN_W'(1) << rd_sz;
    assign wr_step = LEN_W'(1) << wr_sz;

    assign rd_req_valid = (state_q == RUN) && (rd_st_q == R_REQ) && fifo_rready_i && (rd_rem_q != '0);
    assign rd_resp_fire = (rd_st_q == R_RESP) && rd_resp_valid_i;
    assign rd_ok        = rd_resp_fire && !rd_resp_err_i;
    assign wr_req_valid = (state_q == RUN) && (wr_st_q == W_REQ) && fifo_wready_i && (wr_rem_q != '0);
    assign wr_fire      = wr_req_valid && wr_req_ready_i;
    assign wr_resp_fire = (wr_st_q == W_RESP) && wr_resp_valid_i;
    assign wr_ok        = wr_resp_fire && !wr_resp_err_i;
    assign resp_err     = (rd_resp_fire && rd_resp_err_i) || (wr_resp_fire && wr_resp_err_i);

    always_comb begin
        state_d      = state_q;
        rd_st_d      = rd_st_q;
        wr_st_d      = wr_st_q;
        rd_addr_d    = rd_addr_q;
        wr_addr_d    = wr_addr_q;
        rd_rem_d     = rd_rem_q;
        wr_rem_d     = wr_rem_q;
        bytes_done_d = bytes_done_q;
        err_d        = err_q;
        fifo_rstn_o  = 1'b1;

        // Engines advance only on good responses; address/size stay put while a beat is in flight
        if (rd_req_valid && rd_req_ready_i) begin
            rd_st_d = R_RESP;
        end else if (rd_resp_fire) begin
            rd_st_d = R_REQ;
        end
        if (rd_ok) begin
            rd_addr_d = rd_addr_q + ADDR_W'(rd_step);
            rd_rem_d  = rd_rem_q - rd_step;
        end
        if (wr_fire) begin
            wr_st_d = W_RESP;
        end else if (wr_resp_fire) begin
            wr_st_d = W_REQ;
        end
        if (wr_ok) begin
            wr_addr_d    = wr_addr_q + ADDR_W'(wr_step);
            wr_rem_d     = wr_rem_q - wr_step;
            bytes_done_d = bytes_done_q + wr_step;
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    err_d        = 1'b0;
                    bytes_done_d = '0;
                    rd_st_d      = R_REQ;
                    wr_st_d      = W_REQ;
                    if (len_i != '0) begin
                        rd_addr_d = src_addr_i;
                        wr_addr_d = dst_addr_i;
                        rd_rem_d  = len_i;
                        wr_rem_d  = len_i;
                        state_d   = FLUSH;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            FLUSH: begin
                fifo_rstn_o = 1'b0;
                if (abort_hit) begin
                    err_d   = 1'b1;
                    state_d = DRAIN;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (resp_err || abort_hit) begin
                    err_d   = 1'b1;
                    state_d = DRAIN;
                end else if (wr_ok && wr_rem_q == wr_step) begin
                    state_d = DONE;
                end
            end
            DRAIN: begin
                if (rd_st_q == R_REQ && wr_st_q == W_REQ) begin
                    fifo_rstn_o = 1'b0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= IDLE;
            rd_st_q      <= R_REQ;
            wr_st_q      <= W_REQ;
            rd_addr_q    <= '0;
            wr_addr_q    <= '0;
            rd_rem_q     <= '0;
            wr_rem_q     <= '0;
            bytes_done_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_st_q      <= rd_st_d;
            wr_st_q      <= wr_st_d;
            rd_addr_q    <= rd_addr_d;
            wr_addr_q    <= wr_addr_d;
            rd_rem_q     <= rd_rem_d;
            wr_rem_q     <= wr_rem_d;
            bytes_done_q <= bytes_done_d;
            err_q        <= err_d;
        end
    end

    assign busy_o          = (state_q != IDLE);
    assign done_o          = (state_q == DONE);
    assign err_o           = err_q;
    assign bytes_done_o    = bytes_done_q;
    assign rd_req_valid_o  = rd_req_valid;
    assign rd_addr_o       = rd_addr_q;
    assign rd_size_o       = {1'b0, rd_sz};
    assign rd_resp_ready_o = (rd_st_q == R_RESP);
    assign wr_req_valid_o  = wr_req_valid;
    assign wr_addr_o       = wr_addr_q;
    assign wr_size_o       = {1'b0, wr_sz};
    assign fifo_rvalid_o   = rd_ok;
    assign fifo_rsize_o    = {1'b0, rd_sz};
    assign fifo_rladdr_o   = rd_addr_q[1:0];
    assign fifo_wvalid_o   = wr_fire;
    assign fifo_wsize_o    = {1'b0, wr_sz};
    assign fifo_wladdr_o   = wr_addr_q[1:0];

endmodule
